// File: rtl/audio_cic_pkg.sv
// ---------------------------------------------------------------------------
// audio_cic_pkg
// Shared types and constants for the audio CIC clock-enable scheduler.
//   sched_state_t : burst scheduler states (IDLE, IN_BURST, OUT_BURST)
//   STATS_W       : width of the optional saturating drop counters
//   ch_width()    : channel index width for a given channel count (min 1)
// ---------------------------------------------------------------------------
package audio_cic_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IN_BURST  = 2'd1,
        OUT_BURST = 2'd2
    } sched_state_t;

    localparam int STATS_W = 16;

    // A single channel still needs a 1-bit index so ch_idx never collapses to zero width.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_frac_tick.sv
// ---------------------------------------------------------------------------
// audio_frac_tick
// Fractional-N rate generator. It produces a one-cycle tick at an average rate
// of clk * num / den using a phase accumulator.
// Ports:
//   clk      in   master clock
//   reset_n  in   asynchronous active-low reset
//   enable   in   advance the accumulator (0 holds the phase)
//   cfg_load in   latch num/den and zero the accumulator
//   num      in   [ACCW-1:0] rate numerator
//   den      in   [ACCW-1:0] rate denominator
//   tick     out  combinational tick for the current cycle
// ---------------------------------------------------------------------------
module audio_frac_tick #(
    parameter int ACCW = 24
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            cfg_load,
    input  logic [ACCW-1:0] num,
    input  logic [ACCW-1:0] den,
    output logic            tick
);

    logic [ACCW-1:0] num_r;
    logic [ACCW-1:0] den_r;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_next;
    logic [ACCW:0]   sum;
    logic            cfg_valid;
    logic            hit;

    // The sum carries one extra bit so that acc+num can never wrap below den.
    // A zero numerator or denominator means the generator is switched off.
    // When num>=den, the generator ticks every cycle and the phase is held at 0.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, num_r};
        cfg_valid = (num_r != '0) && (den_r != '0);
        hit       = cfg_valid && (sum >= {1'b0, den_r});
        tick      = enable && !cfg_load && hit;
        acc_next  = acc;
        if (enable && cfg_valid) begin
            if (num_r >= den_r) begin
                acc_next = '0;
            end else if (hit) begin
                acc_next = ACCW'(sum - {1'b0, den_r});
            end else begin
                acc_next = sum[ACCW-1:0];
            end
        end
    end

    // cfg_load takes precedence over accumulation, so the first tick can occur no earlier than the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_r <= '0;
            den_r <= '0;
            acc   <= '0;
        end else if (cfg_load) begin
            num_r <= num;
            den_r <= den;
            acc   <= '0;
        end else begin
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/audio_cen_sched.sv
// ---------------------------------------------------------------------------
// audio_cen_sched
// Clock-enable scheduler for the shared, time-multiplexed audio CIC datapath.
// Two fractional-N rate generators produce input-rate and output-rate ticks.
// Each tick is expanded into a burst of NCH one-cycle strobes, one strobe per
// channel slot. Output bursts take priority over input bursts.
// Optional feature macro: AUDIO_CEN_SCHED_STATS_EN. When it is defined, the
// module adds saturating drop counters.
// Ports:
//   clk, reset_n          master clock, asynchronous active-low reset
//   enable                run the rate accumulators
//   cfg_load              latch in_/out_ num/den and zero both accumulators
//   in_num/in_den         input-rate ratio  [ACCW-1:0]
//   out_num/out_den       output-rate ratio [ACCW-1:0]
//   ovf_clr               clear the sticky overflow flags (and the counters)
//   cen_in/cen_out        filter input/output strobes
//   ch_idx [CHW-1:0]      channel slot that owns the current strobe
//   burst_last            the strobe belongs to slot NCH-1
//   ovf_in/ovf_out        sticky flags set when a tick is dropped
//   drop_cnt_in/out       [STATS_W-1:0] saturating drop counts (STATS_EN only)
// ---------------------------------------------------------------------------
module audio_cen_sched
    import audio_cic_pkg::*;
#(
    parameter  int NCH  = 2,
    parameter  int ACCW = 24,
    localparam int CHW  = ch_width(NCH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               cfg_load,
    input  logic [ACCW-1:0]    in_num,
    input  logic [ACCW-1:0]    in_den,
    input  logic [ACCW-1:0]    out_num,
    input  logic [ACCW-1:0]    out_den,
    input  logic               ovf_clr,
    output logic               cen_in,
    output logic               cen_out,
    output logic [CHW-1:0]     ch_idx,
    output logic               burst_last,
    output logic               ovf_in,
    output logic               ovf_out
`ifdef AUDIO_CEN_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0] drop_cnt_in,
    output logic [STATS_W-1:0] drop_cnt_out
`endif
);

    sched_state_t   state;
    sched_state_t   state_next;
    logic [CHW-1:0] slot;
    logic [CHW-1:0] slot_next;
    logic           tick_in;
    logic           tick_out;
    logic           pend_in;
    logic           pend_out;
    logic           take_in;
    logic           take_out;
    logic           drop_in;
    logic           drop_out;
    logic           last_slot;
    logic           free;

    audio_frac_tick #(.ACCW(ACCW)) u_in_rate (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .cfg_load (cfg_load),
        .num      (in_num),
        .den      (in_den),
        .tick     (tick_in)
    );

    audio_frac_tick #(.ACCW(ACCW)) u_out_rate (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .cfg_load (cfg_load),
        .num      (out_num),
        .den      (out_den),
        .tick     (tick_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            state <= state_next;
            slot  <= slot_next;
        end
    end

    // The scheduler makes a decision when it is idle and again on the last slot of every burst.
    // A tick that arrives in this cycle can start a burst at once. This gives a
    // one-cycle latency from tick to strobe, and back-to-back bursts have no gap between them.
    always_comb begin
        state_next = state;
        slot_next  = slot;
        take_in    = 1'b0;
        take_out   = 1'b0;
        last_slot  = (slot == CHW'(NCH - 1));
        free       = (state == IDLE) || last_slot;
        if (free) begin
            slot_next = '0;
            if (pend_out || tick_out) begin
                state_next = OUT_BURST;
                take_out   = 1'b1;
            end else if (pend_in || tick_in) begin
                state_next = IN_BURST;
                take_in    = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end else begin
            slot_next = slot + CHW'(1);
        end
        drop_in  = tick_in  && pend_in  && !take_in;
        drop_out = tick_out && pend_out && !take_out;
    end

    // A burst consumes the pending flag. If a tick arrives in the same cycle
    // as a burst that consumes an older pending tick, the new tick becomes the
    // next pending one. A drop that occurs in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_in  <= 1'b0;
            pend_out <= 1'b0;
            ovf_in   <= 1'b0;
            ovf_out  <= 1'b0;
        end else begin
            pend_in  <= take_in  ? (pend_in  && tick_in)  : (pend_in  || tick_in);
            pend_out <= take_out ? (pend_out && tick_out) : (pend_out || tick_out);
            ovf_in   <= drop_in  || (ovf_in  && !ovf_clr);
            ovf_out  <= drop_out || (ovf_out && !ovf_clr);
        end
    end

`ifdef AUDIO_CEN_SCHED_STATS_EN
    // The counters saturate at all-ones. A drop that occurs together with ovf_clr restarts the count at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_in  <= '0;
            drop_cnt_out <= '0;
        end else begin
            if (drop_in) begin
                drop_cnt_in <= ovf_clr ? STATS_W'(1) :
                               ((&drop_cnt_in) ? drop_cnt_in : drop_cnt_in + STATS_W'(1));
            end else if (ovf_clr) begin
                drop_cnt_in <= '0;
            end
            if (drop_out) begin
                drop_cnt_out <= ovf_clr ? STATS_W'(1) :
                                ((&drop_cnt_out) ? drop_cnt_out : drop_cnt_out + STATS_W'(1));
            end else if (ovf_clr) begin
                drop_cnt_out <= '0;
            end
        end
    end
`endif

    assign cen_in     = (state == IN_BURST);
    assign cen_out    = (state == OUT_BURST);
    assign ch_idx     = slot;
    assign burst_last = (state != IDLE) && last_slot;

endmodule
